// File: rtl/ff_calc_driver.sv
// ---------------------------------------------------------------------------
// ff_calc_driver
//
// Initiator for the four-function calculator's token interface. A host
// buffers an infix expression in a small token FIFO, then pulses start.
// The driver sends CLR, the buffered tokens in order, and EQU. It waits on
// the calculator's ready handshake before each token. Finally it captures
// the answer and presents it with a one-cycle valid pulse. A watchdog
// aborts the sequence if the calculator holds ready low for too long.
//
// Parameters
//   DEPTH    token FIFO entries (power of two, >= 2)
//   TIMEOUT  consecutive stalled cycles (SEND/WAIT with calc_ready=0)
//            that trigger an abort (>= 4)
//
// Ports
//   clk           clock, all logic on the rising edge
//   reset         synchronous, active-high reset
//   wr_en         host write strobe for wr_token (IDLE only)
//   wr_token      host token: 0-9 digit, A +, B -, C *, D /
//   full          FIFO holds DEPTH entries (registered)
//   start         one-cycle pulse: begin sending the buffered expression
//   busy          high while the sequence is in progress
//   result        last captured calculator answer
//   result_valid  one-cycle pulse when result updates
//   error         sticky timeout flag, cleared by reset or accepted start
//   calc_strobe   token write strobe to the calculator
//   calc_token    token to the calculator, valid with calc_strobe
//   calc_ready    calculator can accept a token
//   calc_answer   calculator answer
// ---------------------------------------------------------------------------
module ff_calc_driver #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_token,
  output logic       full,
  input  logic       start,
  output logic       busy,
  output logic [3:0] result,
  output logic       result_valid,
  output logic       error,
  output logic       calc_strobe,
  output logic [3:0] calc_token,
  input  logic       calc_ready,
  input  logic [3:0] calc_answer
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] TOK_EQU = 4'hE;
  localparam logic [3:0] TOK_CLR = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_HOLD,
    S_WAIT,
    S_DONE
  } state_t;

  // Which item the sequencer is currently presenting.
  typedef enum logic [1:0] {
    ITEM_CLR,
    ITEM_FIFO,
    ITEM_EQU
  } item_t;

  state_t state, state_nxt;
  item_t  item, item_nxt;

  // Pointers carry one extra bit so equal low bits with differing top
  // bits means full, fully equal means empty.
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   wr_ptr_nxt, rd_ptr_nxt;
  logic [AW:0]   occupancy_nxt;
  logic [3:0]    mem [DEPTH];

  logic [CW-1:0] tmo_cnt;

  logic          fifo_empty;
  logic          start_ok;
  logic          push;
  logic          pop;
  logic          stall;
  logic          timeout_hit;
  logic          capture;
  logic [3:0]    item_tok;

  // -------------------------------------------------------------------------
  // Qualified events
  // -------------------------------------------------------------------------
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign start_ok   = (state == S_IDLE) && start;

  // CLR/EQU are framing tokens owned by the driver, so the host cannot
  // buffer them.
  assign push = (state == S_IDLE) && wr_en && !full &&
                (wr_token != TOK_EQU) && (wr_token != TOK_CLR);

  // A FIFO entry leaves the buffer on the cycle its strobe is issued.
  assign pop = (state == S_SEND) && calc_ready && (item == ITEM_FIFO);

  assign stall       = ((state == S_SEND) || (state == S_WAIT)) && !calc_ready;
  // Abort on the stalled cycle that brings the count up to TIMEOUT.
  assign timeout_hit = stall && (tmo_cnt == CW'(TIMEOUT - 1));

  // -------------------------------------------------------------------------
  // Current item token
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    item_tok = TOK_CLR;
    case (item)
      ITEM_CLR:  item_tok = TOK_CLR;
      ITEM_FIFO: item_tok = mem[rd_ptr[AW-1:0]];
      ITEM_EQU:  item_tok = TOK_EQU;
      default:   item_tok = TOK_CLR;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequencer next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    item_nxt  = item;
    capture   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SEND;
          item_nxt  = ITEM_CLR;
        end
      end

      // The strobe is ready-gated, so leaving SEND means it fired.
      S_SEND: begin
        if (calc_ready) begin
          state_nxt = S_HOLD;
        end
      end

      // The calculator drops ready one cycle after a strobe. Skipping
      // that cycle keeps a stale ready from launching the next token.
      S_HOLD: begin
        state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (calc_ready) begin
          if (item == ITEM_EQU) begin
            // The answer is valid once the calculator has digested EQU.
            state_nxt = S_DONE;
            capture   = 1'b1;
          end else begin
            state_nxt = S_SEND;
            item_nxt  = fifo_empty ? ITEM_EQU : ITEM_FIFO;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (timeout_hit) begin
      state_nxt = S_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointer update (timeout flushes the buffer)
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (timeout_hit) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + (AW+1)'(1);
    end
  end

  assign occupancy_nxt = wr_ptr_nxt - rd_ptr_nxt;

  // -------------------------------------------------------------------------
  // State, pointers, watchdog and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state   <= S_IDLE;
      item    <= ITEM_CLR;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      full    <= 1'b0;
      tmo_cnt <= '0;
      result  <= 4'h0;
      error   <= 1'b0;
    end else begin
      state  <= state_nxt;
      item   <= item_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      full   <= (occupancy_nxt == (AW+1)'(DEPTH));

      if (calc_ready || timeout_hit) begin
        tmo_cnt <= '0;
      end else if (stall) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end

      if (start_ok) begin
        error <= 1'b0;
      end else if (timeout_hit) begin
        error <= 1'b1;
      end

      if (capture) begin
        result <= calc_answer;
      end
    end
  end

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are live, and leaving it out lets the array map to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_token;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_DONE);
  assign calc_strobe  = (state == S_SEND) && calc_ready;
  assign calc_token   = (state == S_SEND) ? item_tok : 4'h0;

endmodule

// File: tb/tb_ff_calc_driver.sv
// ---------------------------------------------------------------------------
// tb_ff_calc_driver
//
// Drives ff_calc_driver against a behavioural calculator stub with random
// ready latency. The expected token sequence and answer are derived from
// the host writes: CLR, the accepted tokens, EQU, folded left to right.
// ---------------------------------------------------------------------------
module tb_ff_calc_driver;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 10;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       wr_en    = 1'b0;
  logic [3:0] wr_token = 4'h0;
  logic       start    = 1'b0;
  logic       full;
  logic       busy;
  logic [3:0] result;
  logic       result_valid;
  logic       error;
  logic       calc_strobe;
  logic [3:0] calc_token;
  logic       calc_ready;
  logic [3:0] calc_answer;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ff_calc_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_token     (wr_token),
    .full         (full),
    .start        (start),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .error        (error),
    .calc_strobe  (calc_strobe),
    .calc_token   (calc_token),
    .calc_ready   (calc_ready),
    .calc_answer  (calc_answer)
  );

  // -------------------------------------------------------------------------
  // Calculator stub: drops ready the cycle after each accepted token and
  // raises it again after 1..4 cycles, unless stall_force holds it low.
  // -------------------------------------------------------------------------
  logic       stall_force = 1'b0;
  int         busy_cnt;
  logic [3:0] acc, cur, pend;
  logic [3:0] sent_q [$];

  function automatic logic [3:0] calc_op(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    case (op)
      4'hA:    return a + b;
      4'hB:    return a - b;
      4'hC:    return a * b;
      4'hD:    return (b == 4'h0) ? 4'h0 : a / b;
      default: return b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      calc_ready  <= 1'b1;
      calc_answer <= 4'h0;
      acc = 4'h0; cur = 4'h0; pend = 4'h0; busy_cnt = 0;
    end else if (calc_strobe) begin
      sent_q.push_back(calc_token);
      if (calc_token == 4'hF) begin
        acc = 4'h0; cur = 4'h0; pend = 4'h0;
        calc_answer <= 4'h0;
      end else if (calc_token == 4'hE) begin
        acc = calc_op(pend, acc, cur);
        calc_answer <= acc;
        pend = 4'h0; cur = 4'h0;
      end else if (calc_token >= 4'hA) begin
        acc  = calc_op(pend, acc, cur);
        pend = calc_token;
        cur  = 4'h0;
      end else begin
        cur = cur * 4'd10 + calc_token;
      end
      calc_ready <= 1'b0;
      busy_cnt = $urandom_range(1, 4);
    end else if (!calc_ready && !stall_force) begin
      if (busy_cnt <= 1) calc_ready <= 1'b1;
      else busy_cnt = busy_cnt - 1;
    end
  end

  // -------------------------------------------------------------------------
  // Reference: accepted host tokens folded left to right, modulo 16.
  // -------------------------------------------------------------------------
  logic [3:0] exp_fifo [$];
  logic [3:0] host_q [$];

  function automatic logic [3:0] expect_answer(input logic [3:0] q [$]);
    int vals [$];
    logic [3:0] ops [$];
    int num = 0;
    int a;
    foreach (q[i]) begin
      if (q[i] <= 4'd9) num = (num * 10 + int'(q[i])) % 16;
      else begin
        vals.push_back(num);
        ops.push_back(q[i]);
        num = 0;
      end
    end
    vals.push_back(num);
    a = vals[0];
    foreach (ops[i]) begin
      case (ops[i])
        4'hA:    a = (a + vals[i+1]) % 16;
        4'hB:    a = (a - vals[i+1] + 16) % 16;
        4'hC:    a = (a * vals[i+1]) % 16;
        default: a = (vals[i+1] == 0) ? 0 : a / vals[i+1];
      endcase
    end
    return 4'(a);
  endfunction

  // -------------------------------------------------------------------------
  // Handshake monitor: strobe only with ready, >= 3 cycles apart, and
  // result_valid never high on two consecutive cycles.
  // -------------------------------------------------------------------------
  int   cyc         = 0;
  int   last_strobe = -100;
  int   rv_total    = 0;
  logic rv_prev     = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      last_strobe = -100;
      rv_prev     = 1'b0;
    end else begin
      if (calc_strobe === 1'b1) begin
        checks++;
        if (calc_ready !== 1'b1 || (cyc - last_strobe) < 3) begin
          errors++;
          $display("FAIL strobe_handshake: ready=%b gap=%0d, required ready=1 gap>=3",
                   calc_ready, cyc - last_strobe);
        end
        last_strobe = cyc;
      end
      if (result_valid === 1'b1) begin
        rv_total++;
        checks++;
        if (rv_prev) begin
          errors++;
          $display("FAIL result_valid_pulse: high two cycles in a row, required one");
        end
      end
      rv_prev = result_valid;
    end
  end

  // -------------------------------------------------------------------------
  // Host helpers
  // -------------------------------------------------------------------------
  task automatic write_tokens(input string name);
    foreach (host_q[i]) begin
      @(negedge clk);
      checks++;
      if (full !== (exp_fifo.size() == DEPTH)) begin
        errors++;
        $display("FAIL %s full_before_write%0d: got %b, required %b", name, i, full,
                 exp_fifo.size() == DEPTH);
      end
      wr_en    = 1'b1;
      wr_token = host_q[i];
      if (host_q[i] < 4'hE && exp_fifo.size() < DEPTH) exp_fifo.push_back(host_q[i]);
    end
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (full !== (exp_fifo.size() == DEPTH)) begin
      errors++;
      $display("FAIL %s full_after_writes: got %b, required %b", name, full,
               exp_fifo.size() == DEPTH);
    end
  endtask

  task automatic run_expr(input string name, input bit busy_writes, input int same_tok,
                          input int lit_exp);
    logic [3:0] exp_seq [$];
    logic [3:0] exp_res;
    bit done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    if (same_tok >= 0) begin
      wr_en    = 1'b1;
      wr_token = 4'(same_tok);
      if (4'(same_tok) < 4'hE && exp_fifo.size() < DEPTH) exp_fifo.push_back(4'(same_tok));
    end
    exp_seq.push_back(4'hF);
    foreach (exp_fifo[i]) exp_seq.push_back(exp_fifo[i]);
    exp_seq.push_back(4'hE);
    exp_res = expect_answer(exp_fifo);
    exp_fifo.delete();
    sent_q.delete();
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s start_accept: busy=%b error=%b, required busy=1 error=0",
               name, busy, error);
    end
    for (int i = 0; i < 400 && !done; i++) begin
      if (busy_writes) begin
        wr_en    = 1'b1;
        wr_token = 4'($urandom_range(0, 13));
      end
      @(negedge clk);
      if (result_valid === 1'b1) begin
        done  = 1'b1;
        wr_en = 1'b0;
        checks++;
        if (result !== exp_res || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s result: got %h busy=%b, required %h busy=1", name, result,
                   busy, exp_res);
        end
        if (lit_exp >= 0) begin
          checks++;
          if (result !== 4'(lit_exp)) begin
            errors++;
            $display("FAIL %s result_literal: got %h, required %h", name, result,
                     4'(lit_exp));
          end
        end
      end
    end
    wr_en = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s no_result_valid: none within 400 cycles, required one", name);
    end else begin
      @(negedge clk);
      if (result_valid !== 1'b0 || busy !== 1'b0 || full !== 1'b0 || result !== exp_res) begin
        errors++;
        $display("FAIL %s after_done: rv=%b busy=%b full=%b result=%h, required 0 0 0 %h",
                 name, result_valid, busy, full, result, exp_res);
      end
    end
    checks++;
    if (sent_q.size() != exp_seq.size()) begin
      errors++;
      $display("FAIL %s token_count: got %0d, required %0d", name, sent_q.size(),
               exp_seq.size());
    end else begin
      foreach (exp_seq[i]) begin
        checks++;
        if (sent_q[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL %s token%0d: got %h, required %h", name, i, sent_q[i], exp_seq[i]);
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({full, busy, result, result_valid, error, calc_strobe, calc_token} !== 13'd0) begin
      errors++;
      $display("FAIL reset_values: got %b, required all zero",
               {full, busy, result, result_valid, error, calc_strobe, calc_token});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({full, busy, result_valid, error, calc_strobe} !== 5'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b, required 00000",
               {full, busy, result_valid, error, calc_strobe});
    end
  endtask

  task automatic test_add();
    host_q = '{4'h3, 4'hA, 4'h4};
    write_tokens("add");
    run_expr("add", 1'b0, -1, 7);
  endtask

  task automatic test_mixed();
    host_q = '{4'h2, 4'hC, 4'h3, 4'hB, 4'h1};
    write_tokens("mixed");
    run_expr("mixed", 1'b0, -1, 5);
  endtask

  task automatic test_empty_and_dropped();
    host_q.delete();
    run_expr("empty", 1'b0, -1, 0);
    host_q = '{4'hE, 4'hF, 4'hE};
    write_tokens("dropped");
    run_expr("dropped", 1'b0, -1, 0);
  endtask

  task automatic test_same_cycle();
    host_q = '{4'h5, 4'hA};
    write_tokens("same_cycle");
    run_expr("same_cycle", 1'b0, 6, 11);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    host_q = '{4'h7, 4'hC, 4'h2, 4'hA, 4'h3};
    write_tokens("reset_mid");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && seen < 3; i++) begin
      if (calc_strobe === 1'b1) seen++;
      if (seen < 3) @(negedge clk);
    end
    checks++;
    if (seen != 3) begin
      errors++;
      $display("FAIL reset_mid strobes_before_reset: got %0d, required 3", seen);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({full, busy, result, result_valid, error, calc_strobe, calc_token} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid outputs: got %b, required all zero",
               {full, busy, result, result_valid, error, calc_strobe, calc_token});
    end
    reset = 1'b0;
    exp_fifo.delete();
    sent_q.delete();
    repeat (20) @(negedge clk);
    checks++;
    if (sent_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid quiet: strobes=%0d busy=%b, required 0 0", sent_q.size(), busy);
    end
    run_expr("after_reset", 1'b0, -1, 0);
  endtask

  task automatic test_full();
    host_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) host_q.push_back(4'($urandom_range(0, 13)));
    write_tokens("full");
    run_expr("full", 1'b1, -1, -1);
    run_expr("busy_writes_ignored", 1'b0, -1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      host_q.delete();
      for (int i = 0; i < int'($urandom_range(0, DEPTH + 2)); i++)
        host_q.push_back(4'($urandom_range(0, 15)));
      write_tokens("random");
      run_expr("random", 1'b0, -1, -1);
    end
  endtask

  task automatic test_timeout();
    int n;
    int rv_before;
    bit found = 1'b0;
    host_q = '{4'h1, 4'hA, 4'h2};
    write_tokens("timeout");
    exp_fifo.delete();
    rv_before   = rv_total;
    stall_force = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (calc_strobe === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    // One edge leaves SEND, one HOLD cycle, then TIMEOUT stalled cycles.
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (error === 1'b1) break;
    end
    checks++;
    if (!found || n != TIMEOUT + 2) begin
      errors++;
      $display("FAIL timeout_latency: clr_seen=%b cycles=%0d, required 1 %0d", found, n,
               TIMEOUT + 2);
    end
    checks++;
    if (busy !== 1'b0 || full !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: busy=%b full=%b rv=%b, required 0 0 0", busy, full,
               result_valid);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (error !== 1'b1 || rv_total != rv_before) begin
      errors++;
      $display("FAIL timeout_sticky: error=%b rv_pulses=%0d, required 1 0", error,
               rv_total - rv_before);
    end
    stall_force = 1'b0;
    run_expr("after_timeout", 1'b0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mixed();
    test_empty_and_dropped();
    test_same_cycle();
    test_reset_mid();
    test_full();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ff_calc_driver.md
Name: ff_calc_driver

Overview:
- Initiator for the four-function calculator's token interface (`strobe`/`token`/`ready`/`answer`).
- A host loads an infix expression into an internal token FIFO, then pulses `start`.
- The block sends CLR (4'hF), then the buffered tokens in order, then EQU (4'hE), honouring the calculator's `ready` handshake.
- It captures the final answer and presents it with a one-cycle valid pulse. A watchdog aborts if the calculator stalls.

Parameters:
- DEPTH, 8, token FIFO entries (power of two, ≥2).
- TIMEOUT, 255, max consecutive cycles spent waiting for calc_ready before abort (≥4).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  host write strobe for wr_token
- wr_token  in  4  host token: 0-9 digit, A + , B − , C × , D ÷
- full  out  1  FIFO holds DEPTH entries
- start  in  1  one-cycle pulse: begin sending buffered expression
- busy  out  1  high from the cycle after an accepted start until DONE exits
- result  out  4  captured calculator answer, held until next capture/reset
- result_valid  out  1  one-cycle pulse when result updates
- error  out  1  sticky timeout flag; cleared by reset or next accepted start
- calc_strobe  out  1  token write strobe to calculator
- calc_token  out  4  token to calculator, valid when calc_strobe high
- calc_ready  in  1  calculator ready to accept a token
- calc_answer  in  4  calculator answer

Behaviour:
- Reset values:
  - State IDLE, FIFO empty.
  - full=0, busy=0, result=0, result_valid=0, error=0.
  - calc_strobe=0, calc_token=0.
  - Timeout counter 0.
- Reset mid-operation aborts immediately. No further strobes are issued and buffered tokens are discarded.
- FIFO writes:
  - A write is accepted only when state is IDLE, wr_en=1 and full=0.
  - Tokens 4'hE/4'hF are dropped, not stored.
  - Writes while busy or full are ignored, with no side effect.
  - If wr_en and start occur in the same cycle in IDLE, the write is accepted and is included in the expression.
- start:
  - Accepted only in IDLE; ignored otherwise.
  - On acceptance, error clears and the FSM goes to SEND with CLR selected.
- States:
  - IDLE: wait for start.
  - SEND:
    - calc_token = current item.
    - calc_strobe = calc_ready (combinational gating), so the strobe is exactly one cycle and never asserted while calc_ready=0.
    - On a strobe edge → HOLD. Otherwise remain.
  - HOLD: exactly one cycle, covering the calculator's ready-deassert latency, then → WAIT.
  - WAIT: when calc_ready=1, pick the next item and → SEND.
    - Item order: CLR, then each FIFO entry (popped on its strobe edge), then EQU once the FIFO is empty.
    - After EQU's WAIT completes → DONE.
  - DONE (1 cycle):
    - result ← calc_answer; result_valid=1.
    - → IDLE; busy drops the following cycle.
- Empty FIFO at start: the sequence is CLR, EQU; result equals calc_answer, which is 0 after CLR.
- Timeout:
  - The counter increments each cycle in SEND or WAIT with calc_ready=0, and clears on any cycle with calc_ready=1.
  - When it reaches TIMEOUT: error=1, the FIFO is flushed, and → IDLE with no result_valid.
- Arithmetic: 4-bit, modulo-16 results as produced by the calculator. The driver performs no arithmetic.
- Pointers:
  - FIFO pointers wrap modulo DEPTH, with an extra occupancy bit distinguishing full from empty.
  - full is registered and is never high while the FIFO is empty.
- Minimum spacing between consecutive strobes is 3 cycles.

Test Plan:
- Write 3,A,4, then start, with a calculator model → calc_token sequence F,3,A,4,E, one strobe each, no strobe while ready=0; result=7 with a single result_valid pulse.
- Write 2,C,3,B,1 (2*3−1), then start → tokens F,2,C,3,B,1,E; result=5; busy low after DONE; FIFO empty.
- Start with empty FIFO → tokens F,E only; result=0. Writing 4'hE/4'hF then start → same F,E sequence (tokens dropped).
- DEPTH=8: nine writes → full=1 after eighth, ninth ignored. Start → exactly 8 FIFO tokens sent between F and E. Writes during busy are ignored.
- Hold calc_ready=0 after CLR with TIMEOUT=10 → error=1 after the counter reaches 10, FSM IDLE, no result_valid, FIFO empty. The next start clears error.
- Assert reset while in WAIT mid-expression → next cycle all outputs at reset values, no further calc_strobe, subsequent start sends F,E only.
